// File: rtl/matvec_out_requant_if.sv
// Stream bundle around the requantizer: the row-result input side and the requantized output side.
interface matvec_out_requant_if #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 14
);
    logic                    input_valid;
    logic                    input_ready;
    logic signed [IN_W-1:0]  input_data;
    logic                    output_valid;
    logic                    output_ready;
    logic signed [OUT_W-1:0] output_data;
    logic                    output_last;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data, output_last
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data, output_last
    );
endinterface

// File: rtl/matvec_out_requant.sv
// Requantizes 3x3 matvec row results (round-shift, ReLU, saturate) into a small FIFO,
// tags the last row of each output vector and counts saturation events.
module matvec_out_requant #(
    parameter int IN_W    = 28,
    parameter int OUT_W   = 14,
    parameter int SHIFT   = 4,
    parameter bit RELU_EN = 1'b1,
    parameter int DEPTH   = 4,
    parameter int ROWS    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    matvec_out_requant_if.slave   bus,
    input  logic                  sat_clear,
    output logic [7:0]            sat_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Half an output LSB; zero when SHIFT is 0.
    localparam logic signed [IN_W:0]    RND     = (IN_W+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic signed [IN_W:0]    SAT_MAX = (IN_W+1)'(OUT_MAX);
    localparam logic signed [IN_W:0]    SAT_MIN = (IN_W+1)'(OUT_MIN);

    logic                    push;
    logic                    pop;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    row_last;
    logic signed [IN_W:0]    ext_v;
    logic signed [IN_W:0]    rnd_v;
    logic signed [IN_W:0]    shr_v;
    logic signed [IN_W:0]    relu_v;
    logic signed [OUT_W-1:0] sample;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          occ_q, occ_d;
    logic                    ready_q, ready_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [7:0]              sat_q, sat_d;
    logic signed [OUT_W-1:0] data_q [DEPTH];
    logic signed [OUT_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]        last_q, last_d;
    logic [DEPTH-1:0]        wr_en;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Requantization datapath, one bit wider than the input so the rounding add cannot wrap.
    always_comb begin
        ext_v  = {bus.input_data[IN_W-1], bus.input_data};
        rnd_v  = ext_v + RND;
        shr_v  = rnd_v >>> SHIFT;
        relu_v = (RELU_EN && shr_v[IN_W]) ? '0 : shr_v;
        sat_hi = relu_v > SAT_MAX;
        sat_lo = relu_v < SAT_MIN;
        if (sat_hi) begin
            sample = OUT_MAX;
        end else if (sat_lo) begin
            sample = OUT_MIN;
        end else begin
            sample = relu_v[OUT_W-1:0];
        end
    end

    always_comb begin
        push     = bus.input_valid && ready_q;
        pop      = (occ_q != '0) && bus.output_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        // Ready comes only from occupancy, so downstream ready never reaches input_ready combinationally.
        ready_d  = occ_d < (PTR_W+1)'(DEPTH);

        row_last = (row_q == ROW_W'(ROWS-1));
        row_d    = row_q;
        if (push) begin
            row_d = row_last ? '0 : row_q + 1'b1;
        end

        sat_d = sat_q;
        if (sat_clear) begin
            sat_d = '0;
        end else if (push && (sat_hi || sat_lo) && (sat_q != 8'hFF)) begin
            sat_d = sat_q + 8'd1;
        end

        data_d = data_q;
        last_d = last_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                data_d[i] = sample;
                last_d[i] = row_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b0;
            row_q    <= '0;
            sat_q    <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            row_q    <= row_d;
            sat_q    <= sat_d;
            last_q   <= last_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.input_ready  = ready_q;
    assign bus.output_valid = (occ_q != '0);
    assign bus.output_data  = data_q[rd_ptr_q];
    assign bus.output_last  = last_q[rd_ptr_q];
    assign sat_count        = sat_q;
endmodule
